// File: rtl/tetris_line_clear.sv
// rtl/tetris_line_clear.sv - Full-row removal and field compaction after a piece lock
module tetris_line_clear #(
    parameter int ROWS       = 20,
    parameter int COLS       = 10,
    parameter int MAX_REPORT = 4
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic                       start_i,
    input  logic [ROWS-1:0][COLS-1:0]  field_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [ROWS-1:0][COLS-1:0]  field_o,
    output logic [ROWS-1:0]            clear_mask_o,
    output logic [2:0]                 disappear_lines_cnt_o,
    output logic                       update_stat_en_o
);

    localparam int CW = $clog2(ROWS + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                      state;
    logic [ROWS-1:0][COLS-1:0]   src_buf;
    logic [ROWS-1:0][COLS-1:0]   wrk_buf;
    logic [ROWS-1:0][COLS-1:0]   wrk_next;
    logic [ROWS-1:0]             mask;
    logic [ROWS-1:0]             mask_next;
    logic [CW-1:0]               cnt;
    logic [CW-1:0]               cnt_next;
    logic [CW-1:0]               wr_row;
    logic [CW-1:0]               wr_next;
    logic [RW-1:0]               rd_row;
    logic [COLS-1:0]             row;
    logic                        row_full;
    logic [2:0]                  cnt_rep;

    assign row      = src_buf[rd_row];
    assign row_full = &row;

    // Effect of the current scan step: full rows are dropped and counted, others are packed downward
    always_comb begin
        wrk_next  = wrk_buf;
        mask_next = mask;
        cnt_next  = cnt;
        wr_next   = wr_row;
        if (row_full) begin
            mask_next[rd_row] = 1'b1;
            cnt_next          = cnt + CW'(1);
        end else begin
            wrk_next[wr_row[RW-1:0]] = row;
            wr_next                  = wr_row + CW'(1);
        end
    end

    // Reported line count saturates; the removal itself does not
    always_comb begin
        cnt_rep = 3'(cnt_next);
        if (cnt_next > CW'(MAX_REPORT)) begin
            cnt_rep = 3'(MAX_REPORT);
        end
    end

    // Control FSM; results are registered on entry to DONE so they line up with the strobes
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state                 <= IDLE;
            src_buf               <= '0;
            wrk_buf               <= '0;
            mask                  <= '0;
            cnt                   <= '0;
            wr_row                <= '0;
            rd_row                <= '0;
            busy_o                <= 1'b0;
            done_o                <= 1'b0;
            update_stat_en_o      <= 1'b0;
            field_o               <= '0;
            clear_mask_o          <= '0;
            disappear_lines_cnt_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o           <= 1'b0;
                    update_stat_en_o <= 1'b0;
                    if (start_i) begin
                        src_buf <= field_i;
                        wrk_buf <= '0;
                        mask    <= '0;
                        cnt     <= '0;
                        wr_row  <= '0;
                        rd_row  <= '0;
                        busy_o  <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    wrk_buf <= wrk_next;
                    mask    <= mask_next;
                    cnt     <= cnt_next;
                    wr_row  <= wr_next;
                    if (rd_row == RW'(ROWS - 1)) begin
                        field_o               <= wrk_next;
                        clear_mask_o          <= mask_next;
                        disappear_lines_cnt_o <= cnt_rep;
                        done_o                <= 1'b1;
                        update_stat_en_o      <= 1'b1;
                        state                 <= DONE;
                    end else begin
                        rd_row <= rd_row + RW'(1);
                    end
                end
                DONE: begin
                    done_o           <= 1'b0;
                    update_stat_en_o <= 1'b0;
                    busy_o           <= 1'b0;
                    state            <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tetris_line_clear.sv
// tb/tb_tetris_line_clear.sv - Self-checking bench for tetris_line_clear
module tb_tetris_line_clear;

    typedef logic [19:0][9:0] field_t;

    typedef struct {
        field_t      field;
        field_t      exp_field;
        logic [19:0] exp_mask;
        logic [2:0]  exp_cnt;
    } vec_t;

    typedef struct {
        field_t      exp_field;
        logic [19:0] exp_mask;
        logic [2:0]  exp_cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        srst = 1'b0;
    logic        start = 1'b0;
    field_t      field_in = '0;
    logic        busy;
    logic        done;
    field_t      field_out;
    logic [19:0] clear_mask;
    logic [2:0]  lines_cnt;
    logic        update_stat_en;

    int compared = 0;
    int mismatched = 0;

    exp_t sb[$];
    vec_t vecs[6];

    tetris_line_clear dut (
        .clk_i                 (clk),
        .srst_i                (srst),
        .start_i               (start),
        .field_i               (field_in),
        .busy_o                (busy),
        .done_o                (done),
        .field_o               (field_out),
        .clear_mask_o          (clear_mask),
        .disappear_lines_cnt_o (lines_cnt),
        .update_stat_en_o      (update_stat_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic exp_t model(input field_t f);
        exp_t e;
        int   w;
        int   n;
        e.exp_field = '0;
        e.exp_mask  = '0;
        w = 0;
        n = 0;
        for (int r = 0; r < 20; r++) begin
            if (f[r] == 10'h3FF) begin
                e.exp_mask[r] = 1'b1;
                n++;
            end else begin
                e.exp_field[w] = f[r];
                w++;
            end
        end
        e.exp_cnt = (n > 4) ? 3'd4 : 3'(n);
        return e;
    endfunction

    // One transaction: accept at edge T, then watch cycles T+1..T+30.
    // inj_k: cycle at which a stray start is driven (0 = none); rst_k: cycle at which srst pulses (0 = none)
    task automatic run(input field_t f, input exp_t e, input int inj_k, input int rst_k);
        exp_t got;
        bit   exp_done;
        bit   exp_busy;
        bool_reset: begin end
        if (rst_k == 0) sb.push_back(e);
        @(negedge clk);
        start    = 1'b1;
        field_in = f;
        @(negedge clk);
        start    = 1'b0;
        field_in = ~f;
        for (int k = 1; k <= 30; k++) begin
            if (rst_k > 0 && k > rst_k) begin
                exp_done = 1'b0;
                exp_busy = 1'b0;
            end else begin
                exp_done = (rst_k == 0) && (k == 21);
                exp_busy = (k <= 21);
            end
            check($sformatf("busy k=%0d", k), 200'(busy), 200'(exp_busy));
            check($sformatf("done k=%0d", k), 200'(done), 200'(exp_done));
            check($sformatf("upd k=%0d", k), 200'(update_stat_en), 200'(exp_done));
            if (rst_k > 0 && k == rst_k + 1) begin
                check("rst field_o", 200'(field_out), 200'(0));
                check("rst mask", 200'(clear_mask), 200'(0));
                check("rst cnt", 200'(lines_cnt), 200'(0));
            end
            if (done) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL scoreboard: done at k=%0d with nothing expected", k);
                end else begin
                    got = sb.pop_front();
                    check("field_o", 200'(field_out), 200'(got.exp_field));
                    check("clear_mask", 200'(clear_mask), 200'(got.exp_mask));
                    check("lines_cnt", 200'(lines_cnt), 200'(got.exp_cnt));
                end
            end
            start = (k == inj_k);
            if (k == inj_k) field_in = '1;
            srst  = (rst_k > 0) && (k == rst_k);
            @(negedge clk);
        end
        start = 1'b0;
        srst  = 1'b0;
        if (rst_k == 0 && sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: no done_o within budget, %0d pending", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        field_t f;
        exp_t   e;

        for (int i = 0; i < 6; i++) begin
            vecs[i].field     = '0;
            vecs[i].exp_field = '0;
            vecs[i].exp_mask  = '0;
            vecs[i].exp_cnt   = '0;
        end
        // 1: empty field
        // 2: one full row under a partial row
        vecs[1].field[0] = 10'h3FF;
        vecs[1].field[1] = 10'h201;
        vecs[1].exp_field[0] = 10'h201;
        vecs[1].exp_mask = 20'h00001;
        vecs[1].exp_cnt  = 3'd1;
        // 3: tetris
        for (int r = 0; r < 4; r++) vecs[2].field[r] = 10'h3FF;
        vecs[2].field[4] = 10'h0F0;
        vecs[2].exp_field[0] = 10'h0F0;
        vecs[2].exp_mask = 20'h0000F;
        vecs[2].exp_cnt  = 3'd4;
        // 4: interleaved full rows
        vecs[3].field[0] = 10'h001;
        vecs[3].field[1] = 10'h3FF;
        vecs[3].field[2] = 10'h002;
        vecs[3].field[3] = 10'h3FF;
        vecs[3].field[4] = 10'h004;
        vecs[3].exp_field[0] = 10'h001;
        vecs[3].exp_field[1] = 10'h002;
        vecs[3].exp_field[2] = 10'h004;
        vecs[3].exp_mask = 20'h0000A;
        vecs[3].exp_cnt  = 3'd2;
        // 5: six full rows, count saturates
        for (int r = 0; r < 6; r++) vecs[4].field[r] = 10'h3FF;
        vecs[4].exp_mask = 20'h0003F;
        vecs[4].exp_cnt  = 3'd4;
        // 6: every row full, including the top row
        vecs[5].field    = '1;
        vecs[5].exp_mask = 20'hFFFFF;
        vecs[5].exp_cnt  = 3'd4;

        srst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        srst = 1'b0;
        check("reset busy", 200'(busy), 200'(0));
        check("reset done", 200'(done), 200'(0));
        check("reset upd", 200'(update_stat_en), 200'(0));
        check("reset field_o", 200'(field_out), 200'(0));
        check("reset mask", 200'(clear_mask), 200'(0));
        check("reset cnt", 200'(lines_cnt), 200'(0));

        for (int i = 0; i < 6; i++) begin
            e.exp_field = vecs[i].exp_field;
            e.exp_mask  = vecs[i].exp_mask;
            e.exp_cnt   = vecs[i].exp_cnt;
            run(vecs[i].field, e, 0, 0);
        end

        // random fields, checked against a reference compaction
        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < 20; r++) begin
                f[r] = ($urandom_range(0, 2) == 0) ? 10'h3FF : 10'($urandom);
            end
            run(f, model(f), 0, 0);
        end

        // stray start during SCAN is ignored
        run(vecs[3].field, model(vecs[3].field), 5, 0);
        // stray start during DONE is ignored
        run(vecs[1].field, model(vecs[1].field), 21, 0);
        // reset mid-SCAN aborts without a pulse
        run(vecs[2].field, model(vecs[2].field), 0, 10);
        // fresh start after the abort
        run(vecs[3].field, model(vecs[3].field), 0, 0);

        // reset together with start: request dropped
        @(negedge clk);
        srst  = 1'b1;
        start = 1'b1;
        field_in = vecs[1].field;
        @(negedge clk);
        srst  = 1'b0;
        start = 1'b0;
        check("rst+start busy", 200'(busy), 200'(0));
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            check($sformatf("rst+start done k=%0d", k), 200'(done), 200'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
